// File: rtl/oam_dma_if.sv
// Bus bundle between the OAM DMA engine, the CPU write port and the system bus.
// Latency: none (wires only).
// Backpressure: none; the CPU is stalled through cpu_halt while DMA owns the bus.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  mem_rdata;
  logic        cpu_halt;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        busy;

  // DMA engine view
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_halt, bus_sel, dma_addr, dma_rd, dma_we, dma_wdata, busy
  );

  // CPU / system bus view
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_halt, bus_sel, dma_addr, dma_rd, dma_we, dma_wdata, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: copies one 256-byte page to OAM_PORT with interleaved read/write cycles.
// Latency: 513 halted cycles per transfer, 514 when an alignment cycle is needed.
// Backpressure: none accepted; the CPU is stalled via cpu_halt, triggers while busy are dropped.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input logic      clk,
  input logic      rst,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_offset;
  logic [7:0]  r_data;
  logic        r_cpu_halt;
  logic        r_busy;
  logic        r_bus_sel;
  logic        r_dma_rd;
  logic        r_dma_we;
  logic [15:0] r_dma_addr;

  logic        w_trigger;
  logic [7:0]  w_offset_inc;

  assign w_trigger    = bus.cpu_we && (bus.cpu_addr == DMA_REG);
  assign w_offset_inc = r_offset + 8'd1;

  // Every output is a flop so reset clears it immediately and cpu_halt never sees cpu_we combinationally
  assign bus.cpu_halt  = r_cpu_halt;
  assign bus.busy      = r_busy;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.dma_rd    = r_dma_rd;
  assign bus.dma_we    = r_dma_we;
  assign bus.dma_addr  = r_dma_addr;
  assign bus.dma_wdata = r_data;

  // Free-running cycle parity; decides whether the halt must be padded by one alignment cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
    end
  end

  // Transfer FSM; bus outputs are loaded with the values belonging to the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_page     <= 8'h00;
      r_offset   <= 8'h00;
      r_data     <= 8'h00;
      r_cpu_halt <= 1'b0;
      r_busy     <= 1'b0;
      r_bus_sel  <= 1'b0;
      r_dma_rd   <= 1'b0;
      r_dma_we   <= 1'b0;
      r_dma_addr <= 16'h0000;
    end else begin
      r_bus_sel  <= 1'b0;
      r_dma_rd   <= 1'b0;
      r_dma_we   <= 1'b0;
      r_dma_addr <= 16'h0000;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page     <= bus.cpu_wdata;
            r_offset   <= 8'h00;
            r_state    <= S_HALT;
            r_cpu_halt <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_HALT: begin
          if (r_parity) begin
            r_state <= S_ALIGN;
          end else begin
            r_state    <= S_READ;
            r_bus_sel  <= 1'b1;
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, r_offset};
          end
        end
        S_ALIGN: begin
          r_state    <= S_READ;
          r_bus_sel  <= 1'b1;
          r_dma_rd   <= 1'b1;
          r_dma_addr <= {r_page, r_offset};
        end
        S_READ: begin
          // mem_rdata answers the address presented during this READ cycle
          r_data     <= bus.mem_rdata;
          r_state    <= S_WRITE;
          r_bus_sel  <= 1'b1;
          r_dma_we   <= 1'b1;
          r_dma_addr <= OAM_PORT;
        end
        S_WRITE: begin
          if (r_offset == 8'hFF) begin
            // Stop at the page end rather than wrapping the offset into the next page
            r_state    <= S_IDLE;
            r_cpu_halt <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_offset   <= w_offset_inc;
            r_state    <= S_READ;
            r_bus_sel  <= 1'b1;
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, w_offset_inc};
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cpu_halt <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomised directed bench for oam_dma against a page-copy reference model.
// Latency: checks 513/514-cycle halts and first-read timing relative to the trigger.
// Backpressure: none; CPU writes during a transfer must be ignored.
module tb_oam_dma;
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;

  logic clk;
  logic rst;
  oam_dma_if bus ();

  oam_dma #(.DMA_REG(DMA_REG), .OAM_PORT(OAM_PORT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.dma_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Observation record filled by the bus monitor
  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];
  int halt_cnt = 0;
  int perr = 0;
  int first_rd_cyc = -1;
  int trig_cyc = 0;
  int cyc = 0;
  bit exp_par = 1'b0;
  logic mpar;

  always @(posedge clk) cyc <= cyc + 1;

  // Parity of the current cycle: 0 in the first cycle after reset release, toggling each cycle
  always @(posedge clk or posedge rst) begin
    if (rst) mpar <= 1'b0;
    else     mpar <= !mpar;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_halt) halt_cnt++;
      if (bus.busy !== bus.cpu_halt) perr++;
      if (bus.dma_rd) begin
        rd_q.push_back(bus.dma_addr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (!bus.bus_sel || bus.dma_we) perr++;
      end
      if (bus.dma_we) begin
        wr_q.push_back({bus.dma_addr, bus.dma_wdata});
        if (!bus.bus_sel) perr++;
      end
      if (!bus.dma_rd && !bus.dma_we && (bus.bus_sel || bus.dma_addr != 16'h0000)) perr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to a cycle such that a trigger written now lands in a HALT cycle of parity p
  task automatic place_for_parity(input bit p);
    @(posedge clk); #1;
    if ((!mpar) != p) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_xfer(input logic [15:0] addr, input logic [7:0] pg);
    rd_q.delete();
    wr_q.delete();
    halt_cnt     = 0;
    perr         = 0;
    first_rd_cyc = -1;
    exp_par      = !mpar;
    trig_cyc     = cyc;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = pg;
    bus.cpu_we    = 1'b1;
    @(posedge clk); #1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'($urandom);
    bus.cpu_wdata = 8'($urandom);
  endtask

  // Wait for busy to fall; optionally retrigger at DMA_REG k cycles in
  task automatic wait_done(input int mid, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == mid) begin
        bus.cpu_addr  = DMA_REG;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
      end else begin
        bus.cpu_we = 1'b0;
      end
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.cpu_we = 1'b0;
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] pg, input bit ok);
    int rd_bad;
    int wr_bad;
    logic [15:0] a;
    rd_bad = 0;
    wr_bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = {pg, 8'(i)};
      if (i < rd_q.size() && rd_q[i] !== a) rd_bad++;
      if (i < wr_q.size() && wr_q[i] !== {OAM_PORT, mem[a]}) wr_bad++;
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
    chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(513 + int'(exp_par)));
    chk({tag, "_reads"}, 32'(rd_q.size()), 32'd256);
    chk({tag, "_writes"}, 32'(wr_q.size()), 32'd256);
    chk({tag, "_rd_addr_errs"}, 32'(rd_bad), 32'd0);
    chk({tag, "_wr_errs"}, 32'(wr_bad), 32'd0);
    chk({tag, "_first_rd_lat"}, 32'(first_rd_cyc - trig_cyc), 32'(2 + int'(exp_par)));
    chk({tag, "_bus_idle_errs"}, 32'(perr), 32'd0);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int zero_hits;
    logic [7:0] pg;
    logic [7:0] pg2;

    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'd0, bus.cpu_halt, bus.bus_sel, bus.dma_rd, bus.dma_we, bus.busy}, 32'd0);
    chk("rst_addr", {16'd0, bus.dma_addr}, 32'd0);
    chk("rst_wdata", {24'd0, bus.dma_wdata}, 32'd0);
    rst = 1'b0;

    // Page 02, even parity in HALT
    place_for_parity(1'b0);
    start_xfer(DMA_REG, 8'h02);
    wait_done(-1, ok);
    check_xfer("p0_pg02", 8'h02, ok);

    // Page 02, odd parity in HALT: one ALIGN cycle
    place_for_parity(1'b1);
    start_xfer(DMA_REG, 8'h02);
    wait_done(-1, ok);
    check_xfer("p1_pg02", 8'h02, ok);

    // Last page: must stop at FFFF and never touch 0000
    place_for_parity(1'($urandom_range(0, 1)));
    start_xfer(DMA_REG, 8'hFF);
    wait_done(-1, ok);
    check_xfer("pgFF", 8'hFF, ok);
    chk("pgFF_last_rd", {16'd0, (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'h0000}, 32'h0000FFFF);
    zero_hits = 0;
    foreach (rd_q[i]) if (rd_q[i] == 16'h0000) zero_hits++;
    chk("pgFF_no_0000", 32'(zero_hits), 32'd0);

    // Write to a neighbouring register: no transfer
    start_xfer(16'h4015, 8'h33);
    repeat (10) @(negedge clk);
    chk("other_addr_busy", 32'(bus.busy), 32'd0);
    chk("other_addr_halts", 32'(halt_cnt), 32'd0);
    chk("other_addr_reads", 32'(rd_q.size()), 32'd0);

    // Retrigger during a transfer is ignored
    pg = 8'($urandom);
    place_for_parity(1'($urandom_range(0, 1)));
    start_xfer(DMA_REG, pg);
    wait_done(100, ok);
    check_xfer("mid_retrig", pg, ok);

    // Back-to-back: trigger in the first IDLE cycle after completion
    pg = 8'($urandom);
    place_for_parity(1'($urandom_range(0, 1)));
    start_xfer(DMA_REG, pg);
    wait_done(-1, ok);
    check_xfer("chain_a", pg, ok);
    pg2 = pg ^ 8'h5A;
    start_xfer(DMA_REG, pg2);
    wait_done(-1, ok);
    check_xfer("chain_b", pg2, ok);

    // Reset in the WRITE cycle of offset 40
    pg = 8'($urandom);
    place_for_parity(1'($urandom_range(0, 1)));
    start_xfer(DMA_REG, pg);
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (bus.dma_we && rd_q.size() > 0 && rd_q[rd_q.size()-1][7:0] == 8'h40) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {27'd0, bus.cpu_halt, bus.bus_sel, bus.dma_rd, bus.dma_we, bus.busy}, 32'd0);
    chk("rst_mid_addr", {16'd0, bus.dma_addr}, 32'd0);
    chk("rst_mid_wdata", {24'd0, bus.dma_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    halt_cnt = 0;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_halts", 32'(halt_cnt), 32'd0);
    chk("post_rst_access", 32'(rd_q.size() + wr_q.size()), 32'd0);

    // Random pages and parities
    for (int t = 0; t < 3; t++) begin
      pg = 8'($urandom);
      place_for_parity(1'($urandom_range(0, 1)));
      start_xfer(DMA_REG, pg);
      wait_done(-1, ok);
      check_xfer("rand", pg, ok);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
